// File: rtl/demux_sched.sv
// ============================================================================
// Module   : demux_sched
// Brief    : Single-word holding demux that steers each accepted word to the
//            next enabled channel in round-robin order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_sched #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic [3:0]   mask,
    output logic [W-1:0] out_data,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [1:0]   sel,
    output logic [7:0]   count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic [1:0]   sel_q, sel_d;
    logic [1:0]   last_q, last_d;
    logic [7:0]   count_q, count_d;

    logic         xfer_in;
    logic         xfer_out;
    logic [1:0]   next_ch;
    logic         found;
    logic [1:0]   idx;

    // Round-robin search starting one past the previously chosen channel.
    always_comb begin
        next_ch = last_q;
        found   = 1'b0;
        idx     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && mask[idx]) begin
                next_ch = idx;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = 4'b0000;
        in_ready  = 1'b0;
        xfer_out  = 1'b0;
        if (state_q == HOLD) begin
            out_valid = 4'b0001 << sel_q;
            xfer_out  = out_ready[sel_q];
            in_ready  = out_ready[sel_q] && (|mask);
        end else begin
            in_ready  = |mask;
        end
        xfer_in = in_valid && in_ready;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        last_d  = last_q;
        count_d = count_q + {7'd0, xfer_out};
        if (xfer_in) begin
            state_d = HOLD;
            data_d  = in_data;
            sel_d   = next_ch;
            last_d  = next_ch;
        end else if (xfer_out) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign out_data = data_q;
    assign sel      = sel_q;
    assign count    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_sched.sv
// ============================================================================
// Module   : tb_demux_sched
// Brief    : Directed self-checking bench for demux_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_sched;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [3:0]   mask;
    logic [W-1:0] out_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [1:0]   sel;
    logic [7:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    demux_sched #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mask      (mask),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] words [4];
    logic [1:0]   ch2 [6];

    initial begin
        words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3; words[3] = 8'hD4;
        ch2[0] = 2'd0; ch2[1] = 2'd2; ch2[2] = 2'd0;
        ch2[3] = 2'd2; ch2[4] = 2'd0; ch2[5] = 2'd2;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; mask = 4'b0000; out_ready = 4'b0000;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_in_ready_nomask", 32'(in_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Four back-to-back words over all channels
        mask = 4'b1111; out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_data = words[i]; in_valid = 1'b1;
            #1;
            check("b2b_in_ready", 32'(in_ready), 32'h1);
            step();
            check("b2b_sel", 32'(sel), 32'(i));
            check("b2b_out_valid", 32'(out_valid), 32'(4'b0001 << i));
            check("b2b_out_data", 32'(out_data), 32'(words[i]));
            check("b2b_count", 32'(count), 32'(i));
        end
        in_valid = 1'b0;
        step();
        check("b2b_count_final", 32'(count), 32'd4);
        check("b2b_idle_valid", 32'(out_valid), 32'h0);
        check("b2b_sel_retained", 32'(sel), 32'd3);

        // Alternate channels 0 and 2
        mask = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(8'h10 + i); in_valid = 1'b1;
            step();
            check("m0101_sel", 32'(sel), 32'(ch2[i]));
            check("m0101_count", 32'(count), 32'(4 + i));
        end
        in_valid = 1'b0;
        step();
        check("m0101_count_final", 32'(count), 32'd10);

        // Stall on channel 1 while other sinks are ready
        mask = 4'b0010; out_ready = 4'b1101;
        in_data = 8'h55; in_valid = 1'b1;
        step();
        check("stall_sel", 32'(sel), 32'd1);
        in_data = 8'h66;
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", 32'(out_valid), 32'b0010);
            check("stall_out_data", 32'(out_data), 32'h55);
            check("stall_in_ready", 32'(in_ready), 32'h0);
            check("stall_count", 32'(count), 32'd10);
            step();
        end
        out_ready = 4'b1111;
        #1;
        check("stall_release_in_ready", 32'(in_ready), 32'h1);
        step();
        check("stall_delivered_count", 32'(count), 32'd11);
        check("stall_next_data", 32'(out_data), 32'h66);
        check("stall_next_sel", 32'(sel), 32'd1);
        in_valid = 1'b0;
        step();
        check("stall_drain_count", 32'(count), 32'd12);

        // Empty mask blocks acceptance until a channel is enabled
        mask = 4'b0000; in_data = 8'h77; in_valid = 1'b1;
        #1;
        check("nomask_in_ready", 32'(in_ready), 32'h0);
        check("nomask_out_valid", 32'(out_valid), 32'h0);
        step();
        check("nomask_still_idle", 32'(out_valid), 32'h0);
        mask = 4'b1000;
        #1;
        check("m1000_in_ready", 32'(in_ready), 32'h1);
        step();
        check("m1000_sel", 32'(sel), 32'd3);
        check("m1000_out_valid", 32'(out_valid), 32'b1000);
        check("m1000_out_data", 32'(out_data), 32'h77);
        in_valid = 1'b0;
        step();
        check("m1000_count", 32'(count), 32'd13);

        // Mask change while holding must not redirect the word
        mask = 4'b0100; out_ready = 4'b0000; in_data = 8'h88; in_valid = 1'b1;
        step();
        check("hold2_sel", 32'(sel), 32'd2);
        in_valid = 1'b0; mask = 4'b0001;
        step();
        check("hold2_out_valid", 32'(out_valid), 32'b0100);
        check("hold2_out_data", 32'(out_data), 32'h88);
        out_ready = 4'b0100; in_data = 8'h99; in_valid = 1'b1;
        step();
        check("hold2_count", 32'(count), 32'd14);
        check("after_mask_sel", 32'(sel), 32'd0);
        check("after_mask_out_valid", 32'(out_valid), 32'b0001);
        in_valid = 1'b0;

        // Asynchronous reset while holding
        step();
        check("prerst_held", 32'(out_valid), 32'b0001);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_count", 32'(count), 32'h0);
        check("arst_sel", 32'(sel), 32'h0);
        check("arst_out_data", 32'(out_data), 32'h0);
        #1;
        rst = 1'b0;
        mask = 4'b1111; out_ready = 4'b1111; in_data = 8'hAA; in_valid = 1'b1;
        step();
        check("postrst_sel", 32'(sel), 32'd0);
        check("postrst_out_data", 32'(out_data), 32'hAA);
        in_valid = 1'b0;
        step();
        check("postrst_count", 32'(count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux_sched.md
DEMUX_SCHED -- requirements
Module: demux_sched

Interface
REQ-001 Parameter W, default 8, is the data word width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream word available.
REQ-005 in_data  input  W  upstream word.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 mask  input  4  per-channel enable; bit i=1 means channel i is eligible.
REQ-008 out_data  output  W  held word, shared by all channels.
REQ-009 out_valid  output  4  one-hot; bit sel high while the word is offered to channel sel.
REQ-010 out_ready  input  4  per-channel sink ready.
REQ-011 sel  output  2  registered demux select of the held or most recent word.
REQ-012 count  output  8  delivered-word counter.

Function
REQ-013 The block SHALL be a two-state FSM: IDLE (no word held) and HOLD (one word held in out_data).
REQ-014 A transfer in SHALL occur when in_valid && in_ready at a rising edge; a transfer out SHALL occur when out_valid[sel] && out_ready[sel].
REQ-015 In IDLE, in_ready SHALL equal |mask, and out_valid SHALL be 4'b0000.
REQ-016 In HOLD, out_valid SHALL equal the one-hot decode of sel, and in_ready SHALL equal out_ready[sel] && |mask (back-to-back accept).
REQ-017 On a transfer in, the block SHALL latch in_data into out_data and load sel with the first channel enabled in mask, searching upward modulo 4 from last+1, where last is the channel of the previous accepted word.
REQ-018 On a transfer in, last SHALL be updated to the newly chosen channel.
REQ-019 The FSM SHALL move IDLE->HOLD on a transfer in.
REQ-020 The FSM SHALL move HOLD->IDLE on a transfer out without a simultaneous transfer in.
REQ-021 The FSM SHALL stay in HOLD on a simultaneous transfer out and transfer in, with out_data and sel replaced by the new word and channel in that same edge.
REQ-022 Without a transfer out, HOLD SHALL persist indefinitely, and out_data and sel SHALL stay stable.
REQ-023 mask SHALL be sampled only at transfer in; a mask change during HOLD SHALL NOT redirect or drop the held word.
REQ-024 If mask==0, no transfer in SHALL occur; a held word SHALL still be delivered.
REQ-025 count SHALL increment by 1 on each transfer out and wrap from 255 to 0.
REQ-026 Latency SHALL be one cycle: a word accepted at edge N SHALL be offered from edge N onward; throughput SHALL be one word per cycle when the target channel is ready.
REQ-027 out_ready bits other than out_ready[sel] SHALL have no effect.
REQ-028 sel SHALL retain its value in IDLE.

Reset
REQ-029 Asserting rst SHALL immediately force IDLE, out_valid=0, out_data=0, sel=0, last=3, count=0, independent of clk.
REQ-030 A word held when rst asserts SHALL be discarded and not counted.
REQ-031 After rst deasserts, the first accepted word with mask=4'b1111 SHALL go to channel 0.

Verification
REQ-032 mask=1111, all out_ready=1, four words A,B,C,D sent back-to-back -> delivered on channels 0,1,2,3 in consecutive cycles; count=4; in_ready stays 1.
REQ-033 mask=0101, six words sent -> channels 0,2,0,2,0,2; count=6.
REQ-034 Word accepted on channel 1 with out_ready[1]=0 for 5 cycles while out_ready[0,2,3]=1 -> out_valid=0010 held, out_data stable, in_ready=0, count unchanged; delivered on the cycle out_ready[1] rises.
REQ-035 mask=0000 with in_valid=1 -> in_ready=0, out_valid=0; then mask=1000 -> the word is accepted on channel 3.
REQ-036 Word held on channel 2, mask changed to 0001 -> the word is still delivered on channel 2; the next word goes to channel 0.
REQ-037 rst pulsed mid-HOLD between clock edges -> out_valid=0 immediately, count=0, sel=0; the next word goes to channel 0.
